seg_frame_ctrl: RTL and testbench



---
 rtl/seg_frame_ctrl.sv | 112 +++++++++++
 tb/tb_seg_frame_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_frame_ctrl.sv
// seg_frame_ctrl: validates framed RX commands into shadow registers, committed to the display on a periodic tick
module seg_frame_ctrl #(
  parameter int unsigned UPDATE_CYC  = 5_000_000,
  parameter int unsigned TIMEOUT_CYC = 500_000,
  parameter logic [7:0]  HEADER      = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [19:0] data,
  output logic [5:0]  point,
  output logic        en,
  output logic        sign,
  output logic        frame_ok,
  output logic        frame_err,
  output logic        busy
);
  localparam int UW = $clog2(UPDATE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_D0, S_D1, S_D2, S_CHK} state_t;
  state_t state;
  logic [7:0] cmd, d0, d1, d2;
  logic [UW-1:0] tick_cnt;
  logic [TW-1:0] gap;
  logic [19:0] sh_data;
  logic [5:0] sh_point;
  logic sh_en, sh_sign;
  logic tick, expire, last, chk_ok, cmd_ok, val_ok, accept;
  logic [19:0] value;
  always_comb begin
    tick   = tick_cnt == UW'(UPDATE_CYC - 1);
    expire = state != S_IDLE && !rx_valid && gap == TW'(TIMEOUT_CYC - 1);
    value  = {d0[3:0], d1, d2};
    last   = state == S_CHK && rx_valid;
    chk_ok = rx_data == (cmd ^ d0 ^ d1 ^ d2);
    cmd_ok = cmd >= 8'h01 && cmd <= 8'h04;
    val_ok = cmd != 8'h01 || value <= 20'd999999;
    accept = last && chk_ok && cmd_ok && val_ok;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      cmd       <= '0;
      d0        <= '0;
      d1        <= '0;
      d2        <= '0;
      tick_cnt  <= '0;
      gap       <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      sh_data   <= '0;
      sh_point  <= '0;
      sh_sign   <= 1'b0;
      sh_en     <= 1'b1;
      data      <= '0;
      point     <= '0;
      sign      <= 1'b0;
      en        <= 1'b0;
    end else begin
      tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
      gap       <= (rx_valid || state == S_IDLE || expire) ? '0 : gap + 1'b1;
      frame_ok  <= accept;
      frame_err <= (last && !accept) || expire;
      // outputs see the pre-write shadow when a commit and a write share a cycle
      if (tick) begin
        data  <= sh_data;
        point <= sh_point;
        sign  <= sh_sign;
        en    <= sh_en;
      end
      if (accept) begin
        if (cmd == 8'h01) sh_data <= value;
        if (cmd == 8'h02) sh_point <= d2[5:0];
        if (cmd == 8'h03) sh_sign <= d2[0];
        if (cmd == 8'h04) sh_en <= d2[0];
      end
      if (expire) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else if (rx_valid) begin
        case (state)
          S_IDLE: if (rx_data == HEADER) begin
            state <= S_CMD;
            busy  <= 1'b1;
          end
          S_CMD: begin
            cmd   <= rx_data;
            state <= S_D0;
          end
          S_D0: begin
            d0    <= rx_data;
            state <= S_D1;
          end
          S_D1: begin
            d1    <= rx_data;
            state <= S_D2;
          end
          S_D2: begin
            d2    <= rx_data;
            state <= S_CHK;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_seg_frame_ctrl.sv
// tb_seg_frame_ctrl: directed frame scenarios against seg_frame_ctrl with hand-computed expectations
module tb_seg_frame_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0;
  logic [19:0] data;
  logic [5:0] point;
  logic en, sign, frame_ok, frame_err, busy;
  int checks = 0;
  int errors = 0;
  int n = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  seg_frame_ctrl #(.UPDATE_CYC(10), .TIMEOUT_CYC(20), .HEADER(8'hA5)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .data(data), .point(point), .en(en), .sign(sign),
    .frame_ok(frame_ok), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // n = posedges since reset release; edge n with n%10==0 is a commit tick
  always @(posedge clk) begin
    n <= rst ? 0 : n + 1;
    if (frame_ok) ok_cnt <= ok_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
    if (frame_ok && frame_err) both_cnt <= both_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data = '0;
  endtask

  task automatic send_frame(input logic [47:0] f);
    for (int i = 0; i < 6; i++) send_byte(f[47-8*i -: 8]);
  endtask

  task automatic wait_tick();
    do @(negedge clk); while (n % 10 != 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({data, point, en, sign, frame_ok, frame_err, busy} !== 31'd0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%0d point=%b en=%b sign=%b ok=%b err=%b busy=%b, expected all zero",
               data, point, en, sign, frame_ok, frame_err, busy);
    end
    rst = 1'b0;
    wait_tick();
    checks++;
    if (en !== 1'b1 || data !== 20'd0) begin
      errors++;
      $display("FAIL first_tick: got en=%b data=%0d, expected en=1 data=0", en, data);
    end
  endtask

  task automatic test_set_value();
    send_byte(8'h00);
    send_byte(8'h3C);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_drop_busy: got %b expected 0", busy);
    end
    send_frame(48'hA5_01_0F_42_3F_73);
    checks++;
    if ({frame_ok, frame_err} !== 2'b10) begin
      errors++;
      $display("FAIL t1_pulse: got ok=%b err=%b expected ok=1 err=0", frame_ok, frame_err);
    end
    @(negedge clk);
    checks++;
    if ({frame_ok, frame_err} !== 2'b00) begin
      errors++;
      $display("FAIL t1_pulse_width: got ok=%b err=%b expected 0 0", frame_ok, frame_err);
    end
    wait_tick();
    checks++;
    if (data !== 20'd999999 || point !== 6'd0 || sign !== 1'b0 || en !== 1'b1) begin
      errors++;
      $display("FAIL t1_commit: got data=%0d point=%b sign=%b en=%b expected 999999 000000 0 1",
               data, point, sign, en);
    end
  endtask

  task automatic test_range();
    send_frame(48'hA5_01_0F_42_40_0C);
    checks++;
    if ({frame_ok, frame_err} !== 2'b01) begin
      errors++;
      $display("FAIL t2_pulse: got ok=%b err=%b expected ok=0 err=1", frame_ok, frame_err);
    end
    for (int i = 0; i < 3; i++) begin
      wait_tick();
      checks++;
      if (data !== 20'd999999) begin
        errors++;
        $display("FAIL t2_hold%0d: got data=%0d expected 999999", i, data);
      end
    end
  endtask

  task automatic test_checksum();
    send_frame(48'hA5_02_00_00_15_FF);
    checks++;
    if ({frame_ok, frame_err} !== 2'b01) begin
      errors++;
      $display("FAIL t3_badchk_pulse: got ok=%b err=%b expected ok=0 err=1", frame_ok, frame_err);
    end
    wait_tick();
    checks++;
    if (point !== 6'd0) begin
      errors++;
      $display("FAIL t3_point_kept: got %b expected 000000", point);
    end
    send_frame(48'hA5_02_00_00_15_17);
    checks++;
    if ({frame_ok, frame_err} !== 2'b10) begin
      errors++;
      $display("FAIL t3_goodchk_pulse: got ok=%b err=%b expected ok=1 err=0", frame_ok, frame_err);
    end
    wait_tick();
    checks++;
    if (point !== 6'b010101) begin
      errors++;
      $display("FAIL t3_point_set: got %b expected 010101", point);
    end
  endtask

  task automatic test_timeout();
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h00);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL t4_busy_mid: got %b expected 1", busy);
    end
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 19) begin
        checks++;
        if (frame_err !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL t4_before: got err=%b busy=%b expected 0 1", frame_err, busy);
        end
      end
      if (k == 20) begin
        checks++;
        if (frame_err !== 1'b1 || busy !== 1'b0 || frame_ok !== 1'b0) begin
          errors++;
          $display("FAIL t4_expire: got err=%b busy=%b ok=%b expected 1 0 0", frame_err, busy, frame_ok);
        end
      end
      if (k == 21) begin
        checks++;
        if (frame_err !== 1'b0) begin
          errors++;
          $display("FAIL t4_after: got err=%b expected 0", frame_err);
        end
      end
    end
    send_frame(48'hA5_03_00_00_01_02);
    wait_tick();
    checks++;
    if (sign !== 1'b1 || data !== 20'd999999 || point !== 6'b010101) begin
      errors++;
      $display("FAIL t4_sign: got sign=%b data=%0d point=%b expected 1 999999 010101", sign, data, point);
    end
  endtask

  task automatic test_tick_collision();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h07);
    while (n % 10 != 9) @(negedge clk);
    send_byte(8'h06);
    checks++;
    if (frame_ok !== 1'b1 || n % 10 != 0) begin
      errors++;
      $display("FAIL t5_accept_on_tick: got ok=%b n%%10=%0d expected ok=1 n%%10=0", frame_ok, n % 10);
    end
    checks++;
    if (data !== 20'd999999) begin
      errors++;
      $display("FAIL t5_old_at_tick: got data=%0d expected 999999", data);
    end
    wait_tick();
    checks++;
    if (data !== 20'd7) begin
      errors++;
      $display("FAIL t5_new_next_tick: got data=%0d expected 7", data);
    end
  endtask

  task automatic test_reset_mid_frame();
    int ok0, err0;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    ok0 = ok_cnt;
    err0 = err_cnt;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({data, point, en, sign, frame_ok, frame_err, busy} !== 31'd0) begin
      errors++;
      $display("FAIL t6_reset_outputs: got data=%0d point=%b en=%b sign=%b ok=%b err=%b busy=%b expected all zero",
               data, point, en, sign, frame_ok, frame_err, busy);
    end
    rst = 1'b0;
    repeat (25) @(negedge clk);
    checks++;
    if (ok_cnt != ok0 || err_cnt != err0) begin
      errors++;
      $display("FAIL t6_no_pulse: got ok_pulses=%0d err_pulses=%0d expected %0d %0d",
               ok_cnt - ok0, err_cnt - err0, 0, 0);
    end
    send_frame(48'hA5_01_00_00_05_04);
    checks++;
    if ({frame_ok, frame_err} !== 2'b10) begin
      errors++;
      $display("FAIL t6_pulse: got ok=%b err=%b expected ok=1 err=0", frame_ok, frame_err);
    end
    wait_tick();
    checks++;
    if (data !== 20'd5 || en !== 1'b1 || sign !== 1'b0 || point !== 6'd0) begin
      errors++;
      $display("FAIL t6_commit: got data=%0d en=%b sign=%b point=%b expected 5 1 0 000000",
               data, en, sign, point);
    end
  endtask

  initial begin
    test_reset();
    test_set_value();
    test_range();
    test_checksum();
    test_timeout();
    test_tick_collision();
    test_reset_mid_frame();
    checks++;
    if (both_cnt != 0) begin
      errors++;
      $display("FAIL ok_err_exclusive: got %0d overlapping cycles expected 0", both_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
